pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and fetch-sequencing stage that sits directly upstream of `instruction_memory` and drives its `PC_out` address input every cycle. It holds the architectural PC, selects the next PC from sequential, branch, and jump sources, and inserts a boot bubble while the instruction memory leaves reset. It supports halt/resume, traps misaligned redirect targets to a fixed vector, and counts accepted fetches.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h00000000, PC loaded on reset
- `TRAP_VECTOR`, 32'h00000100, PC loaded after a misaligned redirect

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  freeze PC (downstream not ready)
- `branch_taken`  in  1  conditional branch resolved taken this cycle
- `branch_target`  in  32  branch destination
- `jump`  in  1  JAL/JALR redirect this cycle
- `jump_target`  in  32  jump destination
- `halt_req`  in  1  enter HALT
- `resume`  in  1  leave HALT
- `PC_out`  out  32  fetch address to `instruction_memory`
- `PC_plus4`  out  32  `PC_out + 4`, combinational, modulo 2^32
- `fetch_valid`  out  1  high exactly when state is RUN
- `misaligned`  out  1  sticky flag: a redirect target had `[1:0] != 0`
- `trap_pc`  out  32  the most recent offending target
- `state`  out  2  BOOT=00, RUN=01, HALT=10, TRAP=11
- `fetch_count`  out  32  number of accepted fetches

## Operation
- Reset (`reset`=1 at edge): state=BOOT, `PC_out`=RESET_VECTOR, `misaligned`=0, `trap_pc`=0, `fetch_count`=0. `fetch_valid`=0. Reset overrides everything, including mid-HALT and mid-TRAP.
- BOOT: PC holds. Goes to RUN unconditionally on the next edge, giving a one-cycle bubble.
- RUN: the action is chosen in fixed priority, highest first:
  - `halt_req`: go to HALT; PC holds.
  - `stall`: PC holds. The redirect inputs are ignored, and the source must keep asserting them until `stall` drops.
  - `jump`: if `jump_target[1:0]`==0, then PC=jump_target. Otherwise go to TRAP, PC=TRAP_VECTOR, `misaligned`=1, `trap_pc`=jump_target.
  - `branch_taken`: same rule, using `branch_target`.
  - Otherwise PC=PC+4. 32'hFFFFFFFC wraps to 0.
  - `jump` and `branch_taken` asserted together: jump wins and the branch is dropped.
- HALT: PC holds. `resume`=1 returns to RUN with PC unchanged. `halt_req` and redirect inputs are ignored while in HALT.
- TRAP: lasts exactly one cycle with PC=TRAP_VECTOR, then goes to RUN. All inputs except `reset` are ignored.
- `misaligned` stays set until reset. A later misaligned redirect overwrites `trap_pc`.
- `fetch_count` increments on every edge where state=RUN and neither `halt_req` nor `stall` is asserted. This includes cycles that redirect or trap. It wraps modulo 2^32.

## Timing
- All outputs except `PC_plus4` are registered. A redirect sampled at edge N appears on `PC_out` after edge N, so the target instruction appears at `instruction_memory` in cycle N+1.
- After reset is released, the first valid fetch of RESET_VECTOR is in the second cycle (the BOOT bubble).
- Halt: `halt_req` at edge N gives `fetch_valid`=0 from cycle N+1.
- Resume: `resume` at edge M gives `fetch_valid`=1 from cycle M+1 at the same PC.
- Misaligned redirect at edge N: cycle N+1 has state=TRAP, `PC_out`=TRAP_VECTOR, `fetch_valid`=0. Cycle N+2 has state=RUN, `PC_out`=TRAP_VECTOR, `fetch_valid`=1.
- `PC_plus4` tracks `PC_out` in the same cycle.

## Test plan
- Reset, then 4 free-running cycles: `PC_out` reads 0 (BOOT, `fetch_valid`=0), then 0, 4, 8, 12 with `fetch_valid`=1. `fetch_count` ends at 4.
- In RUN at PC=8, pulse `jump`=1 with `jump_target`=32'h40 and `branch_taken`=1 with `branch_target`=32'h80 together. Next `PC_out`=32'h40, then 32'h44.
- Pulse `branch_taken` with `branch_target`=32'h22. Next cycle: state=TRAP, `PC_out`=32'h100, `misaligned`=1, `trap_pc`=32'h22. Following cycle: RUN with `PC_out`=32'h100, then 32'h104.
- At PC=32'h10, hold `stall` for 3 cycles while asserting `jump`: PC stays 32'h10 and `fetch_count` is frozen. Drop `stall` with `jump` still high: PC jumps to the target.
- At PC=32'h20, assert `halt_req`: PC stays 32'h20 and `fetch_valid`=0 for 5 cycles despite redirects. Assert `resume`: `fetch_valid`=1 at 32'h20, then 32'h24. Assert `reset` mid-HALT: state=BOOT, PC=0, `misaligned`=0.
- Jump to 32'hFFFFFFFC: `PC_plus4`=0 in that cycle, and the next `PC_out`=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding instruction_memory: next-PC select, boot bubble, halt, misalignment trap.
// Latency: a redirect sampled at edge N drives PC_out after edge N. PC_plus4 is combinational from PC_out.
// Backpressure: stall or halt_req freezes the PC and the fetch counter. Redirects are dropped while stalled, so the source must hold them.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h00000100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] PC_out,
  output logic [31:0] PC_plus4,
  output logic        fetch_valid,
  output logic        misaligned,
  output logic [31:0] trap_pc,
  output logic [1:0]  state,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_TRAP = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // Redirect source after priority resolution: jump beats branch.
  logic        redir_vld;
  logic [31:0] redir_tgt;

  // Next-state, next-PC and bookkeeping for the current cycle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    misaligned_d  = misaligned_q;
    trap_pc_d     = trap_pc_q;
    fetch_count_d = fetch_count_q;
    redir_vld     = 1'b0;
    redir_tgt     = 32'h0;

    if (jump) begin
      redir_vld = 1'b1;
      redir_tgt = jump_target;
    end else if (branch_taken) begin
      redir_vld = 1'b1;
      redir_tgt = branch_target;
    end

    unique case (state_q)
      // One-cycle bubble while instruction memory comes out of reset.
      ST_BOOT: state_d = ST_RUN;

      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          // Every unstalled RUN cycle counts, including redirects and traps.
          fetch_count_d = fetch_count_q + 32'd1;
          if (redir_vld) begin
            if (redir_tgt[1:0] == 2'b00) begin
              pc_d = redir_tgt;
            end else begin
              state_d      = ST_TRAP;
              pc_d         = TRAP_VECTOR;
              misaligned_d = 1'b1;
              trap_pc_d    = redir_tgt;
            end
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end

      // Everything except resume is ignored; PC is preserved across the halt.
      ST_HALT: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      // Single-cycle trap bubble at TRAP_VECTOR, then fetch from it.
      ST_TRAP: state_d = ST_RUN;

      default: state_d = ST_BOOT;
    endcase
  end

  // State registers with synchronous reset overriding every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      misaligned_q  <= 1'b0;
      trap_pc_q     <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      misaligned_q  <= misaligned_d;
      trap_pc_q     <= trap_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign PC_out      = pc_q;
  assign PC_plus4    = pc_q + 32'd4;
  assign fetch_valid = (state_q == ST_RUN);
  assign misaligned  = misaligned_q;
  assign trap_pc     = trap_pc_q;
  assign state       = state_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed walk through the fetch scenarios, then randomized traffic.
// Every cycle all outputs are compared against a cycle-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h00000000;
  localparam logic [31:0] TV = 32'h00000100;
  localparam int BOOT = 0, RUN = 1, HALT = 2, TRAP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] PC_out, PC_plus4, trap_pc, fetch_count;
  logic        fetch_valid, misaligned;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural view of the fetch stage.
  int          m_mode;
  logic [31:0] m_pc, m_tpc;
  longint      m_fetches;
  bit          m_mis;

  pc_fetch_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .halt_req(halt_req), .resume(resume),
    .PC_out(PC_out), .PC_plus4(PC_plus4), .fetch_valid(fetch_valid),
    .misaligned(misaligned), .trap_pc(trap_pc), .state(state),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply the architectural rules to the inputs seen at this edge.
  task automatic model_edge();
    logic [31:0] dest;
    bit          redirect;
    if (reset) begin
      m_mode = BOOT; m_pc = RV; m_mis = 0; m_tpc = 0; m_fetches = 0;
      return;
    end
    if (m_mode == BOOT || m_mode == TRAP) begin
      m_mode = RUN;
    end else if (m_mode == HALT) begin
      if (resume) m_mode = RUN;
    end else if (halt_req) begin
      m_mode = HALT;
    end else if (!stall) begin
      m_fetches = m_fetches + 1;
      redirect = jump || branch_taken;
      dest = jump ? jump_target : branch_target;
      if (!redirect) begin
        m_pc = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
      end else if (dest % 4 == 0) begin
        m_pc = dest;
      end else begin
        m_mode = TRAP; m_pc = TV; m_mis = 1; m_tpc = dest;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, PC_out, m_pc);
    check({tag, ".pc4"}, PC_plus4, 32'((64'(m_pc) + 4) % 64'h1_0000_0000));
    check({tag, ".valid"}, {31'b0, fetch_valid}, (m_mode == RUN) ? 32'd1 : 32'd0);
    check({tag, ".mis"}, {31'b0, misaligned}, {31'b0, m_mis});
    check({tag, ".tpc"}, trap_pc, m_tpc);
    check({tag, ".state"}, {30'b0, state}, 32'(m_mode));
    check({tag, ".cnt"}, fetch_count, 32'(m_fetches % 64'h1_0000_0000));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; branch_taken = 0; jump = 0; halt_req = 0; resume = 0;
  endtask

  initial begin
    logic [31:0] cnt_hold;
    m_mode = BOOT; m_pc = RV; m_mis = 0; m_tpc = 0; m_fetches = 0;

    // Reset state
    #1; reset = 1;
    step("rst");
    check("rst.state_k", {30'b0, state}, 32'd0);
    check("rst.pc_k", PC_out, 32'h0);
    check("rst.cnt_k", fetch_count, 32'h0);
    idle_inputs();

    // Boot bubble then sequential fetch
    step("boot");
    check("boot.pc0", PC_out, 32'h0);
    check("boot.valid", {31'b0, fetch_valid}, 32'd1);
    step("seq4");
    check("seq.pc4", PC_out, 32'h4);
    step("seq8");
    check("seq.pc8", PC_out, 32'h8);

    // Jump and branch together: jump wins
    jump = 1; jump_target = 32'h40; branch_taken = 1; branch_target = 32'h80;
    step("jb");
    check("jb.pc40", PC_out, 32'h40);
    idle_inputs();
    step("jb_next");
    check("jb.pc44", PC_out, 32'h44);

    // Misaligned branch traps for one cycle
    branch_taken = 1; branch_target = 32'h22;
    step("trap");
    check("trap.state_k", {30'b0, state}, 32'd3);
    check("trap.pc_k", PC_out, 32'h100);
    check("trap.tpc_k", trap_pc, 32'h22);
    check("trap.mis_k", {31'b0, misaligned}, 32'd1);
    idle_inputs();
    step("trap_run");
    check("trap.run_pc", PC_out, 32'h100);
    check("trap.run_valid", {31'b0, fetch_valid}, 32'd1);
    step("trap_seq");
    check("trap.pc104", PC_out, 32'h104);

    // Stall holds PC and counter while a jump is pending
    jump = 1; jump_target = 32'h10;
    step("to10");
    stall = 1; jump_target = 32'h200;
    cnt_hold = fetch_count;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stall.pc_k", PC_out, 32'h10);
      check("stall.cnt_k", fetch_count, cnt_hold);
    end
    stall = 0;
    step("unstall");
    check("unstall.pc_k", PC_out, 32'h200);
    idle_inputs();

    // Halt ignores redirects; resume restores the same PC
    jump = 1; jump_target = 32'h20;
    step("to20");
    idle_inputs();
    halt_req = 1;
    for (int i = 0; i < 5; i++) begin
      step("halt");
      check("halt.pc_k", PC_out, 32'h20);
      check("halt.valid_k", {31'b0, fetch_valid}, 32'd0);
      jump = 1; jump_target = 32'h300; branch_taken = 1; branch_target = 32'h33;
    end
    idle_inputs();
    resume = 1;
    step("resume");
    check("resume.pc_k", PC_out, 32'h20);
    check("resume.valid_k", {31'b0, fetch_valid}, 32'd1);
    idle_inputs();
    step("resume_seq");
    check("resume.pc24", PC_out, 32'h24);

    // Reset in the middle of HALT
    halt_req = 1;
    step("halt2");
    halt_req = 0; reset = 1;
    step("rst_halt");
    check("rst_halt.state_k", {30'b0, state}, 32'd0);
    check("rst_halt.mis_k", {31'b0, misaligned}, 32'd0);
    check("rst_halt.pc_k", PC_out, 32'h0);
    idle_inputs();

    // Reset in the middle of TRAP
    step("boot2");
    jump = 1; jump_target = 32'h1001;
    step("trap2");
    idle_inputs(); reset = 1;
    step("rst_trap");
    check("rst_trap.state_k", {30'b0, state}, 32'd0);
    check("rst_trap.tpc_k", trap_pc, 32'h0);
    idle_inputs();

    // PC wrap at the top of the address space
    step("boot3");
    jump = 1; jump_target = 32'hFFFFFFFC;
    step("top");
    check("wrap.pc4_k", PC_plus4, 32'h0);
    idle_inputs();
    step("wrap");
    check("wrap.pc_k", PC_out, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(63) == 0);
      stall         = ($urandom_range(3) == 0);
      halt_req      = ($urandom_range(9) == 0);
      resume        = ($urandom_range(2) == 0);
      jump          = ($urandom_range(5) == 0);
      branch_taken  = ($urandom_range(4) == 0);
      jump_target   = $urandom;
      branch_target = $urandom;
      if ($urandom_range(3) != 0) jump_target[1:0] = 2'b00;
      if ($urandom_range(3) != 0) branch_target[1:0] = 2'b00;
      step("rand");
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
